dmem_banked: RTL and testbench

Parametrised byte-addressed data memory for the MEM stage. Storage is split into byte-lane banks, with a valid/ready request port and a registered response port. Word accesses are big-endian and may be misaligned; a misaligned word costs one extra cycle. After reset, a sweep FSM zeroes the array before any request is accepted.

---
 rtl/dmem_pkg.sv | 8 +
 rtl/dmem_bank.sv | 17 +
 rtl/dmem_banked.sv | 126 ++++++++++++
 tb/tb_dmem_banked.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states, access-size codes and boot signature bytes for dmem_banked
package dmem_pkg;
    typedef enum logic [1:0] {INIT, IDLE, SPLIT} state_t;
    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_WORD = 1'b1;
    localparam logic [7:0] BOOT_B0 = 8'hAB;
    localparam logic [7:0] BOOT_B1 = 8'h99;
endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: one byte lane of storage with synchronous write and registered read
module dmem_bank #(
    parameter int ROWS = 64,
    parameter int RW   = 6
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [RW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem [ROWS];
    always_ff @(posedge clk)
        if (en && we) mem[addr] <= wdata;
        else if (en) rdata <= mem[addr];
endmodule

// File: rtl/dmem_banked.sv
// dmem_banked: byte-lane banked data memory with big-endian misaligned words; DMEM_BOOT_SIG_EN seeds bytes 0/1
module dmem_banked
    import dmem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int NB   = DATA_W / 8;
    localparam int ROWS = DEPTH / NB;
    localparam int RW   = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int OW   = NB > 1 ? $clog2(NB) : 1;

    state_t            state;
    logic [RW-1:0]     k, row;
    logic [OW-1:0]     off, o_off;
    logic [ADDR_W-1:0] c_addr, a;
    logic [DATA_W-1:0] c_wdata, wd;
    logic              c_we, we, size, accept, err, mis, o_rd, o_size;
    logic [7:0]        q [NB];

    // SPLIT replays the captured request so lane steering is shared with IDLE
    always_comb begin
        a      = state == SPLIT ? c_addr : req_addr;
        we     = state == SPLIT ? c_we : req_we;
        wd     = state == SPLIT ? c_wdata : req_wdata;
        size   = state == SPLIT ? SZ_WORD : req_size;
        row    = RW'(a / ADDR_W'(NB));
        off    = OW'(a % ADDR_W'(NB));
        accept = req_valid && req_ready;
        err    = ({1'b0, req_addr} + (req_size == SZ_WORD ? (ADDR_W+1)'(NB) : (ADDR_W+1)'(1)))
                 > (ADDR_W+1)'(DEPTH);
        mis    = req_size == SZ_WORD && off != '0 && !err;
    end

    // Misaligned reads fetch every lane in SPLIT so bank outputs change only with the response
    for (genvar l = 0; l < NB; l++) begin : g_lane
        logic          en, lwe;
        logic [RW-1:0] laddr;
        logic [7:0]    lwd, sig;
        int            bi;
        always_comb begin
`ifdef DMEM_BOOT_SIG_EN
            sig   = int'(k) * NB + l == 0 ? BOOT_B0 : int'(k) * NB + l == 1 ? BOOT_B1 : 8'h00;
`else
            sig   = 8'h00;
`endif
            bi    = (l + NB - int'(off)) % NB;
            en    = state == INIT || (state == SPLIT && (!c_we || l < int'(off)))
                    || (accept && !err && (size == SZ_BYTE ? l == int'(off)
                                                           : off == '0 || (we && l >= int'(off))));
            lwe   = state == INIT || we;
            laddr = state == INIT ? k : l >= int'(off) ? row : row + RW'(1);
            lwd   = state == INIT ? sig : size == SZ_BYTE ? wd[7:0] : 8'(wd >> (DATA_W - 8 - 8 * bi));
        end
        dmem_bank #(.ROWS(ROWS), .RW(RW)) u_bank (
            .clk(clk), .en(en), .we(lwe), .addr(laddr), .wdata(lwd), .rdata(q[l])
        );
    end

    always_comb begin
        rsp_rdata = '0;
        for (int i = 0; i < NB; i++)
            if (o_rd && o_size == SZ_WORD) rsp_rdata[DATA_W-1-8*i -: 8] = q[(int'(o_off) + i) % NB];
        if (o_rd && o_size == SZ_BYTE) rsp_rdata[7:0] = q[o_off];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            k         <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            o_rd      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                INIT: begin
                    k <= k + RW'(1);
                    if (k == RW'(ROWS - 1)) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                IDLE: if (accept) begin
                    c_addr  <= req_addr;
                    c_we    <= req_we;
                    c_wdata <= req_wdata;
                    if (mis) begin
                        state     <= SPLIT;
                        req_ready <= 1'b0;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        o_rd      <= !req_we && !err;
                        o_size    <= req_size;
                        o_off     <= off;
                    end
                end
                SPLIT: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    o_rd      <= !c_we;
                    o_size    <= SZ_WORD;
                    o_off     <= off;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_banked.sv
// tb_dmem_banked: random and directed stimulus against a byte-array reference model of dmem_banked
module tb_dmem_banked;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 16;
    localparam int NB     = DATA_W / 8;
    localparam int ROWS   = DEPTH / NB;
`ifdef DMEM_BOOT_SIG_EN
    localparam logic [DATA_W-1:0] BOOT = 16'hAB99;
`else
    localparam logic [DATA_W-1:0] BOOT = 16'h0000;
`endif

    logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_we = 1'b0, req_size = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic req_ready, rsp_valid, rsp_err;
    logic [DATA_W-1:0] rsp_rdata;

    always #5 clk = ~clk;

    dmem_banked #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    int checks = 0, failures = 0, pulses = 0, m_init = 0;
    logic [7:0] mem [DEPTH];
    bit e_ready, e_valid, e_err, s2v, m_block, got_err;
    logic [DATA_W-1:0] e_data, s2d, got;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (mem[i]) mem[i] = 8'h00;
`ifdef DMEM_BOOT_SIG_EN
        mem[0] = 8'hAB;
        mem[1] = 8'h99;
`endif
        e_ready = 0; e_valid = 0; e_err = 0; e_data = '0;
        s2v = 0; m_init = ROWS; m_block = 0;
    endtask

    // one clock: drive at negedge, predict, advance, compare at the next negedge
    task automatic cycle(input bit v, input bit we, input bit sz, input int addr, input logic [DATA_W-1:0] wd);
        bit acc, err, mis, n_v, n_e;
        logic [DATA_W-1:0] d, n_d;
        req_valid = v; req_we = we; req_size = sz; req_addr = ADDR_W'(addr); req_wdata = wd;
        acc = v && e_ready && !rst;
        mis = 0; n_v = s2v; n_e = 0; n_d = s2d; s2v = 0;
        if (acc) begin
            err = addr + (sz ? NB : 1) > DEPTH;
            mis = sz && (addr % NB) != 0 && !err;
            d = '0;
            if (!err && we) begin
                if (sz) for (int i = 0; i < NB; i++) mem[addr+i] = wd[DATA_W-1-8*i -: 8];
                else mem[addr] = wd[7:0];
            end else if (!err) begin
                if (sz) for (int i = 0; i < NB; i++) d[DATA_W-1-8*i -: 8] = mem[addr+i];
                else d = DATA_W'(mem[addr]);
            end
            if (mis) begin s2v = 1; s2d = d; end
            else begin n_v = 1; n_e = err; n_d = d; end
        end
        if (rst) model_reset();
        else begin
            if (n_v) begin e_err = n_e; e_data = n_d; end
            e_valid = n_v;
            if (m_init > 0) begin m_init--; e_ready = m_init == 0; end
            else if (m_block) begin m_block = 0; e_ready = 1; end
            else if (acc && mis) begin m_block = 1; e_ready = 0; end
        end
        @(posedge clk);
        @(negedge clk);
        check("req_ready", req_ready, e_ready);
        check("rsp_valid", rsp_valid, e_valid);
        check("rsp_err", rsp_err, e_err);
        check("rsp_rdata", rsp_rdata, e_data);
        if (rsp_valid) begin got = rsp_rdata; got_err = rsp_err; pulses++; end
    endtask

    task automatic wait_init();
        int n = 0;
        while (!req_ready && n < 200) begin cycle(0, 0, 0, 0, '0); n++; end
        check("init_len", n, ROWS);
    endtask

    initial begin
        int p0;
        model_reset();
        @(negedge clk);
        repeat (3) cycle(0, 0, 0, 0, '0);
        rst = 0;
        wait_init();
        got = 'x; cycle(1, 0, 1, 0, '0);
        check("boot_rd", {got_err, got}, {1'b0, BOOT});

        cycle(1, 1, 1, 4, 16'h1234);
        got = 'x; cycle(1, 0, 0, 4, '0);
        check("rd_b4", got, 16'h0012);
        got = 'x; cycle(1, 0, 0, 5, '0);
        check("rd_b5", got, 16'h0034);

        cycle(1, 1, 1, 7, 16'hBEEF);
        check("split_ready_w", req_ready, 0);
        cycle(0, 0, 0, 0, '0);
        got = 'x; cycle(1, 0, 1, 7, '0);
        check("split_ready_r", req_ready, 0);
        cycle(0, 0, 0, 0, '0);
        check("rd_w7", got, 16'hBEEF);
        got = 'x; cycle(1, 0, 0, 8, '0);
        check("rd_b8", got, 16'h00EF);

        got = 'x; cycle(1, 0, 1, 127, '0);
        check("oor_w127", {got_err, got}, 17'h10000);
        got = 'x; cycle(1, 1, 0, 200, 16'h0055);
        check("oor_b200", {got_err, got}, 17'h10000);
        cycle(1, 1, 1, 127, 16'hCAFE);
        got = 'x; cycle(1, 0, 0, 127, '0);
        check("b127_kept", {got_err, got}, 17'h00000);

        cycle(1, 1, 1, 2, 16'h5566);
        cycle(1, 0, 1, 3, '0);
        p0 = pulses;
        rst = 1;
        cycle(0, 0, 0, 0, '0);
        rst = 0;
        check("rst_split_nopulse", pulses - p0, 0);
        wait_init();
        got = 'x; cycle(1, 0, 1, 2, '0);
        check("wiped", got, 16'h0000);

        p0 = pulses;
        for (int i = 0; i < 4; i++) cycle(1, 0, 1, 2 * i, '0);
        check("b2b_pulses", pulses - p0, 4);

        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 399) == 0;
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 1) != 0 ? $urandom_range(0, 15) : $urandom_range(0, DEPTH + 3),
                  DATA_W'($urandom));
        end
        rst = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
